// File: rtl/fxp_pkg.sv
// fxp_pkg: shared rounding-mode type and rounding helper
// for the fixed-point round/saturate pipeline.
package fxp_pkg;

  localparam int FXP_DW = 64;
  localparam int FXP_RW = FXP_DW + 1;

  typedef enum logic [1:0] {
    RND_HALF_AWAY,
    RND_TRUNC,
    RND_FLOOR,
    RND_CEIL
  } round_mode_e;

  // Works at a fixed wide width; callers sign-extend in and narrow out.
  function automatic logic [FXP_RW-1:0] fxp_round(
    input logic signed [FXP_DW-1:0] d,
    input int unsigned              frac_w,
    input round_mode_e              mode
  );
    logic signed [FXP_RW-1:0] ip;
    logic [FXP_DW-1:0] mask;
    logic [FXP_DW-1:0] f;
    logic [FXP_DW-1:0] half;
    logic nz;
    logic up;
    ip   = FXP_RW'(d >>> frac_w);
    mask = (FXP_DW'(1) << frac_w) - FXP_DW'(1);
    f    = d & mask;
    half = mask ^ (mask >> 1);
    nz   = |f;
    up   = 1'b0;
    unique case (mode)
      RND_FLOOR:     up = 1'b0;
      RND_CEIL:      up = nz;
      RND_TRUNC:     up = d[FXP_DW-1] & nz;
      RND_HALF_AWAY: up = nz & (d[FXP_DW-1] ? (f > half)
                                            : (f >= half));
    endcase
    return ip + FXP_RW'(up);
  endfunction

endpackage

// File: rtl/fxp_sat_clamp.sv
// fxp_sat_clamp: combinational signed clamp from IN_W
// down to OUT_W bits, flagging when the value changed.
module fxp_sat_clamp #(
  parameter int IN_W  = 9,
  parameter int OUT_W = 8
) (
  input  logic [IN_W-1:0]  din,
  output logic [OUT_W-1:0] dout,
  output logic             sat
);

  logic [IN_W-OUT_W:0] hi;
  logic fits;

  // Fits iff every bit from the output sign bit upward agrees.
  assign hi   = din[IN_W-1:OUT_W-1];
  assign fits = (&hi) | ~(|hi);
  assign sat  = ~fits;

  always_comb begin
    dout = din[OUT_W-1:0];
    if (!fits) begin
      dout = din[IN_W-1] ? {1'b1, {(OUT_W-1){1'b0}}}
                         : {1'b0, {(OUT_W-1){1'b1}}};
    end
  end

endmodule

// File: rtl/fxp_round_sat.sv
// fxp_round_sat: two-stage streaming Qm.FRAC_W -> OUT_W
// integer converter (S1 round, S2 saturate) with clamp counter.
module fxp_round_sat
  import fxp_pkg::*;
#(
  parameter int IN_W      = 16,
  parameter int FRAC_W    = 8,
  parameter int OUT_W     = 8,
  parameter int SAT_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_W-1:0]      in_data,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 out_sat,
  output logic [SAT_CNT_W-1:0] sat_count,
  input  logic                 sat_clr
);

  localparam int RW = IN_W - FRAC_W + 1;

  logic              v1;
  logic [RW-1:0]     r1;
  logic              v2;
  logic [OUT_W-1:0]  d2;
  logic              s2;
  logic              en1;
  logic              en2;
  logic [FXP_RW-1:0] rnd;
  logic [OUT_W-1:0]  clamp_d;
  logic              clamp_s;

  assign en2      = !v2 || out_ready;
  assign en1      = !v1 || en2;
  assign in_ready = en1;

  assign rnd = fxp_round(FXP_DW'(signed'(in_data)),
                         unsigned'(FRAC_W),
                         round_mode_e'(in_mode));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1 <= 1'b0;
      r1 <= '0;
    end else if (en1) begin
      v1 <= in_valid;
      if (in_valid) r1 <= RW'(rnd);
    end
  end

  fxp_sat_clamp #(
    .IN_W (RW),
    .OUT_W(OUT_W)
  ) u_clamp (
    .din (r1),
    .dout(clamp_d),
    .sat (clamp_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2 <= 1'b0;
      d2 <= '0;
      s2 <= 1'b0;
    end else if (en2) begin
      v2 <= v1;
      if (v1) begin
        d2 <= clamp_d;
        s2 <= clamp_s;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sat_count <= '0;
    end else if (sat_clr) begin
      sat_count <= '0;
    end else if (v2 && out_ready && s2 && !(&sat_count)) begin
      sat_count <= sat_count + 1'b1;
    end
  end

  assign out_valid = v2;
  assign out_data  = d2;
  assign out_sat   = s2;

endmodule

// File: tb/tb_fxp_round_sat.sv
// tb_fxp_round_sat: directed vectors on a default-width
// converter and a narrow one (OUT_W=4, 2-bit counter).
module tb_fxp_round_sat;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [15:0] in_data;
  logic [1:0]  in_mode;
  logic        out_ready;
  logic        sat_clr;

  logic        a_in_ready;
  logic        a_out_valid;
  logic [7:0]  a_out_data;
  logic        a_out_sat;
  logic [15:0] a_sat_count;

  logic        b_in_ready;
  logic        b_out_valid;
  logic [3:0]  b_out_data;
  logic        b_out_sat;
  logic [1:0]  b_sat_count;

  int n_checks = 0;
  int n_fail   = 0;

  fxp_round_sat u_a (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (a_in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .out_valid(a_out_valid),
    .out_ready(out_ready),
    .out_data (a_out_data),
    .out_sat  (a_out_sat),
    .sat_count(a_sat_count),
    .sat_clr  (sat_clr)
  );

  fxp_round_sat #(
    .IN_W     (16),
    .FRAC_W   (8),
    .OUT_W    (4),
    .SAT_CNT_W(2)
  ) u_b (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (b_in_ready),
    .in_data  (in_data),
    .in_mode  (in_mode),
    .out_valid(b_out_valid),
    .out_ready(out_ready),
    .out_data (b_out_data),
    .out_sat  (b_out_sat),
    .sat_count(b_sat_count),
    .sat_clr  (sat_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed: A is Q8.8 -> int8, B is Q8.8 -> int4.
  logic [15:0] tab_d  [0:12] = '{
    16'h7B73, 16'h7BA6, 16'hFD80, 16'hFD80, 16'hFD80,
    16'hFD80, 16'h0280, 16'hC800, 16'h3800, 16'h7FFF,
    16'h7FFF, 16'h7F80, 16'h8000};
  logic [1:0]  tab_m  [0:12] = '{
    2'd0, 2'd0, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0,
    2'd0, 2'd0, 2'd3, 2'd0, 2'd0, 2'd3};
  logic [7:0]  tab_a  [0:12] = '{
    8'h7B, 8'h7C, 8'hFD, 8'hFE, 8'hFD, 8'hFE, 8'h03,
    8'hC8, 8'h38, 8'h7F, 8'h7F, 8'h7F, 8'h80};
  logic        tab_as [0:12] = '{
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [3:0]  tab_b  [0:12] = '{
    4'h7, 4'h7, 4'hD, 4'hE, 4'hD, 4'hE, 4'h3,
    4'h8, 4'h7, 4'h7, 4'h7, 4'h7, 4'h8};
  logic        tab_bs [0:12] = '{
    1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
    1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int k);
    chk({tag, "_a_data"}, 32'(a_out_data), 32'(tab_a[k]));
    chk({tag, "_a_sat"},  32'(a_out_sat),  32'(tab_as[k]));
    chk({tag, "_b_data"}, 32'(b_out_data), 32'(tab_b[k]));
    chk({tag, "_b_sat"},  32'(b_out_sat),  32'(tab_bs[k]));
  endtask

  // One isolated beat: checks latency, value and drain.
  task automatic one(input int k, input logic clr);
    string t;
    t = $sformatf("v%0d", k);
    in_valid  = 1'b1;
    in_data   = tab_d[k];
    in_mode   = tab_m[k];
    out_ready = 1'b1;
    #1;
    chk({t, "_in_ready"}, 32'(a_in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({t, "_lat1"}, 32'(a_out_valid), 32'd0);
    @(posedge clk); #1;
    chk({t, "_lat2"}, 32'(a_out_valid), 32'd1);
    chk_out(t, k);
    sat_clr = clr;
    @(posedge clk); #1;
    sat_clr = 1'b0;
    chk({t, "_drain"}, 32'(a_out_valid), 32'd0);
  endtask

  initial begin
    int sent;
    int got;
    logic held_v;
    logic [7:0] held_d;
    logic held_s;
    logic any_v;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    in_mode   = '0;
    out_ready = 1'b0;
    sat_clr   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 32'(a_out_valid), 32'd0);
    chk("rst_out_data",  32'(a_out_data),  32'd0);
    chk("rst_out_sat",   32'(a_out_sat),   32'd0);
    chk("rst_sat_count", 32'(a_sat_count), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rst_in_ready", 32'(a_in_ready), 32'd1);

    for (int k = 0; k < 13; k++) one(k, 1'b0);
    chk("a_sat_count3", 32'(a_sat_count), 32'd3);
    chk("b_sat_stick",  32'(b_sat_count), 32'd3);

    // Clear coincides with a saturating handshake.
    one(9, 1'b1);
    chk("a_clr_wins", 32'(a_sat_count), 32'd0);
    chk("b_clr_wins", 32'(b_sat_count), 32'd0);

    // Stream 10 beats under random backpressure.
    sent   = 0;
    got    = 0;
    held_v = 1'b0;
    held_d = '0;
    held_s = 1'b0;
    for (int cyc = 0; cyc < 400 && got < 10; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = (sent < 10);
      in_data   = tab_d[sent % 10];
      in_mode   = tab_m[sent % 10];
      #1;
      if (a_out_valid && out_ready) begin
        chk_out($sformatf("s%0d", got), got);
        got++;
      end
      if (!a_out_valid || out_ready) begin
        chk("s_in_ready_a", 32'(a_in_ready), 32'd1);
        chk("s_in_ready_b", 32'(b_in_ready), 32'd1);
      end
      held_v = a_out_valid && !out_ready;
      held_d = a_out_data;
      held_s = a_out_sat;
      if (in_valid && a_in_ready) sent++;
      @(posedge clk); #1;
      if (held_v) begin
        chk("s_hold_valid", 32'(a_out_valid), 32'd1);
        chk("s_hold_data",  32'(a_out_data),  32'(held_d));
        chk("s_hold_sat",   32'(a_out_sat),   32'(held_s));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("s_delivered", 32'(got), 32'd10);
    repeat (3) @(posedge clk);
    #1;
    chk("s_no_extra",  32'(a_out_valid), 32'd0);
    chk("s_a_count",   32'(a_sat_count), 32'd1);
    chk("s_b_count",   32'(b_sat_count), 32'd3);

    // Reset with two beats in flight.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = tab_d[9];
    in_mode   = tab_m[9];
    @(posedge clk); #1;
    in_data = tab_d[6];
    in_mode = tab_m[6];
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("r_inflight", 32'(a_out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("r_out_valid", 32'(a_out_valid), 32'd0);
    chk("r_out_data",  32'(a_out_data),  32'd0);
    chk("r_out_sat",   32'(a_out_sat),   32'd0);
    chk("r_a_count",   32'(a_sat_count), 32'd0);
    chk("r_b_count",   32'(b_sat_count), 32'd0);
    @(posedge clk); #1;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    any_v     = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
      any_v |= a_out_valid;
    end
    chk("r_discarded", 32'(any_v), 32'd0);
    one(6, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
